matrix_frame_scheduler: RTL and testbench

// Sequences one LED-matrix frame into the SPI Output_Module. It walks COLUMNS columns of

---
 rtl/matrix_frame_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_matrix_frame_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler: walks one LED-matrix frame column by column, fetching each lane
// word from the frame buffer and handing it to the SPI Output_Module with start strobes.

module matrix_frame_scheduler #(
    parameter int CHANNEL_NUMBER   = 3,
    parameter int SPI_SIZE         = 24,
    parameter int COLUMNS          = 16,
    parameter int WORDS_PER_COLUMN = 8,
    parameter int ADDR_WIDTH       = $clog2(COLUMNS*WORDS_PER_COLUMN)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               frame_ready,
    output logic                               rd_en,
    output logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_out,
    output logic                               new_image,
    output logic                               new_column,
    input  logic                               next_data,
    input  logic                               tx_finish,
    output logic                               busy,
    output logic [$clog2(COLUMNS)-1:0]         column_idx,
    output logic                               frame_done,
    output logic                               protocol_err
);
    localparam int COL_W  = $clog2(COLUMNS);
    localparam int WORD_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;
    localparam int STAGES = 1;

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLUMNS - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_COLUMN - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_RD, LOAD, XFER, WAIT_TX, NEXT_COL, DONE
    } state_t;

    state_t                                  state;
    logic [WORD_W-1:0]                       word_cnt;
    logic                                    pending;
    // [0]: read strobe issued this cycle, [STAGES]: read data present on rd_data
    logic [STAGES:0]                         vld_pipe;
    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] rd_lane;
    logic [CHANNEL_NUMBER-1:0][SPI_SIZE-1:0] lane_q;

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [COL_W-1:0]  col,
                                                        input logic [WORD_W-1:0] word);
        return ADDR_WIDTH'(col) * ADDR_WIDTH'(WORDS_PER_COLUMN) + ADDR_WIDTH'(word);
    endfunction

    assign rd_en    = vld_pipe[0];
    assign rd_lane  = rd_data;
    assign data_out = lane_q;

    genvar g;
    generate
        for (g = 0; g < CHANNEL_NUMBER; g++) begin : g_lane
            matrix_frame_lane #(.SPI_SIZE(SPI_SIZE)) u_lane (
                .clk  (clk),
                .rst  (rst),
                .load (vld_pipe[STAGES]),
                .din  (rd_lane[g]),
                .dout (lane_q[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            word_cnt     <= '0;
            pending      <= 1'b0;
            vld_pipe     <= '0;
            rd_addr      <= '0;
            new_image    <= 1'b0;
            new_column   <= 1'b0;
            busy         <= 1'b0;
            column_idx   <= '0;
            frame_done   <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            new_column <= 1'b0;
            new_image  <= 1'b0;
            frame_done <= 1'b0;
            vld_pipe   <= {vld_pipe[STAGES-1:0], 1'b0};
            if (frame_ready)
                pending <= 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (next_data && state == IDLE)
                        protocol_err <= 1'b1;
                    // a frame_ready in this very cycle counts just like a held one
                    if (enable && (frame_ready || pending)) begin
                        pending     <= 1'b0;
                        busy        <= 1'b1;
                        column_idx  <= '0;
                        word_cnt    <= '0;
                        rd_addr     <= '0;
                        vld_pipe[0] <= 1'b1;
                        state       <= FETCH;
                    end else if (state == DONE) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                FETCH: begin
                    if (next_data)
                        protocol_err <= 1'b1;
                    state <= WAIT_RD;
                end

                WAIT_RD: begin
                    if (next_data)
                        protocol_err <= 1'b1;
                    if (word_cnt == '0) begin
                        new_column <= 1'b1;
                        new_image  <= (column_idx == '0);
                    end
                    state <= LOAD;
                end

                LOAD: begin
                    if (next_data)
                        protocol_err <= 1'b1;
                    state <= XFER;
                end

                XFER: begin
                    if (tx_finish) begin
                        // column cut short by the output stage: flag it, still move on
                        protocol_err <= 1'b1;
                        if (column_idx == LAST_COL) begin
                            column_idx <= '0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            column_idx <= column_idx + 1'b1;
                            state      <= NEXT_COL;
                        end
                    end else if (next_data) begin
                        if (word_cnt == LAST_WORD) begin
                            state <= WAIT_TX;
                        end else begin
                            word_cnt    <= word_cnt + 1'b1;
                            rd_addr     <= word_addr(column_idx, word_cnt + 1'b1);
                            vld_pipe[0] <= 1'b1;
                            state       <= FETCH;
                        end
                    end
                end

                WAIT_TX: begin
                    if (next_data)
                        protocol_err <= 1'b1;
                    if (tx_finish) begin
                        if (column_idx == LAST_COL) begin
                            column_idx <= '0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            column_idx <= column_idx + 1'b1;
                            state      <= NEXT_COL;
                        end
                    end
                end

                NEXT_COL: begin
                    word_cnt    <= '0;
                    rd_addr     <= word_addr(column_idx, '0);
                    vld_pipe[0] <= 1'b1;
                    state       <= FETCH;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// One lane's output word register: loads the frame-buffer read data when it arrives.
module matrix_frame_lane #(
    parameter int SPI_SIZE = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SPI_SIZE-1:0] din,
    output logic [SPI_SIZE-1:0] dout
);
    always_ff @(posedge clk) begin
        if (rst)
            dout <= '0;
        else if (load)
            dout <= din;
    end
endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Bench for matrix_frame_scheduler: a RAM model answers reads while the main sequence plays
// the Output_Module and checks every word and strobe against the frame contents.
`timescale 1ns/1ps
module tb_matrix_frame_scheduler;
    localparam int CH   = 3;
    localparam int SW   = 24;
    localparam int COLS = 16;
    localparam int WPC  = 8;
    localparam int AW   = $clog2(COLS*WPC);
    localparam int DW   = CH*SW;
    localparam int CW   = $clog2(COLS);

    logic          clk = 1'b0;
    logic          rst, enable, frame_ready, next_data, tx_finish;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] data_out;
    logic          new_image, new_column, busy, frame_done, protocol_err;
    logic [CW-1:0] column_idx;

    logic [DW-1:0] mem [COLS*WPC];
    int checks = 0;
    int errors = 0;
    int nc_cnt = 0, ni_cnt = 0, fd_cnt = 0;
    int rd_log[$];
    logic exp_perr = 1'b0;

    always #5 clk = ~clk;

    matrix_frame_scheduler #(
        .CHANNEL_NUMBER(CH), .SPI_SIZE(SW), .COLUMNS(COLS), .WORDS_PER_COLUMN(WPC)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .frame_ready(frame_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out),
        .new_image(new_image), .new_column(new_column), .next_data(next_data),
        .tx_finish(tx_finish), .busy(busy), .column_idx(column_idx),
        .frame_done(frame_done), .protocol_err(protocol_err)
    );

    // frame buffer: one-cycle read latency
    always @(posedge clk)
        if (rd_en) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (rd_en)      rd_log.push_back(int'(rd_addr));
        if (new_column) nc_cnt++;
        if (new_image)  ni_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_next();
        next_data = 1'b1; tick(1); next_data = 1'b0;
    endtask

    task automatic pulse_tx();
        tx_finish = 1'b1; tick(1); tx_finish = 1'b0;
    endtask

    task automatic pulse_ready();
        frame_ready = 1'b1; tick(1); frame_ready = 1'b0;
    endtask

    task automatic wait_new_column();
        int n = 0;
        while (!new_column && n < 12) begin
            tick(1);
            n++;
        end
        check("new_column arrives", new_column, 1'b1);
    endtask

    // Entered in the cycle new_column is visible; sends n_next next_data pulses, then tx_finish.
    task automatic column_body(input int col, input bit fr, input int n_next);
        check("column_idx", column_idx, col);
        check("new_image", new_image, col == 0);
        check("word0 data", data_out, mem[col*WPC]);
        for (int w = 1; w <= n_next; w++) begin
            tick(int'($urandom_range(1, 10)));
            if (fr && w == 4) pulse_ready();
            pulse_next();
            if (w < WPC) begin
                check("fetch strobe", rd_en, 1'b1);
                check("fetch addr", rd_addr, col*WPC + w);
                tick(2);
                check("word data", data_out, mem[col*WPC + w]);
                check("no mid-column strobe", new_column, 1'b0);
            end else begin
                check("no fetch after last word", rd_en, 1'b0);
            end
        end
        tick(int'($urandom_range(2, 30)));
        pulse_tx();
        check("column_idx advance", column_idx, (col + 1) % COLS);
        check("frame_done", frame_done, col == COLS - 1);
        check("protocol_err", protocol_err, exp_perr);
    endtask

    task automatic do_column(input int col, input bit fr);
        wait_new_column();
        column_body(col, fr, WPC);
    endtask

    initial begin
        int base, nc0, ni0, fd0, bad;

        for (int i = 0; i < COLS*WPC; i++)
            mem[i] = DW'({$urandom(), $urandom(), $urandom()});

        rst = 1'b1; enable = 1'b0; frame_ready = 1'b0; next_data = 1'b0; tx_finish = 1'b0;
        tick(3);
        check("reset rd_en", rd_en, 1'b0);
        check("reset rd_addr", rd_addr, 0);
        check("reset data_out", data_out, 0);
        check("reset new_image", new_image, 1'b0);
        check("reset new_column", new_column, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset column_idx", column_idx, 0);
        check("reset frame_done", frame_done, 1'b0);
        check("reset protocol_err", protocol_err, 1'b0);
        rst = 1'b0;
        tick(2);
        check("idle without frame", busy, 1'b0);

        // frame 1: exact start latency, then a full frame
        enable = 1'b1;
        tick(1);
        base = rd_log.size(); nc0 = nc_cnt; ni0 = ni_cnt; fd0 = fd_cnt;
        pulse_ready();
        check("start rd_en", rd_en, 1'b1);
        check("start rd_addr", rd_addr, 0);
        check("start busy", busy, 1'b1);
        tick(1);
        check("single read strobe", rd_en, 1'b0);
        check("no early new_column", new_column, 1'b0);
        tick(1);
        check("first new_column", new_column, 1'b1);
        column_body(0, 1'b0, WPC);
        for (int c = 1; c < COLS; c++) do_column(c, 1'b0);
        tick(1);
        check("frame1 back to idle", busy, 1'b0);
        check("frame_done one cycle", frame_done, 1'b0);
        check("frame1 read count", rd_log.size() - base, COLS*WPC);
        bad = 0;
        for (int i = 0; i < COLS*WPC; i++)
            if (base + i < rd_log.size() && rd_log[base + i] != i) bad++;
        check("frame1 address order", bad, 0);
        check("frame1 new_column count", nc_cnt - nc0, COLS);
        check("frame1 new_image count", ni_cnt - ni0, 1);
        check("frame1 frame_done count", fd_cnt - fd0, 1);

        // frame 2 with two frame_ready pulses: frame 3 must follow straight from DONE
        pulse_ready();
        check("frame2 start", rd_en, 1'b1);
        for (int c = 0; c < COLS; c++) do_column(c, (c == 3) || (c == 9));
        tick(1);
        check("restart from done rd_en", rd_en, 1'b1);
        check("restart from done rd_addr", rd_addr, 0);
        check("restart from done busy", busy, 1'b1);
        for (int c = 0; c < COLS; c++) do_column(c, 1'b0);
        tick(1);
        check("pulses collapsed busy", busy, 1'b0);
        check("pulses collapsed rd_en", rd_en, 1'b0);
        tick(5);
        check("still idle", busy, 1'b0);

        // frame 4: enable dropped at column 5, frame_ready held during column 8
        base = rd_log.size();
        pulse_ready();
        check("frame4 start", rd_en, 1'b1);
        for (int c = 0; c < COLS; c++) begin
            if (c == 5) enable = 1'b0;
            do_column(c, c == 8);
        end
        tick(1);
        check("disabled frame ends idle", busy, 1'b0);
        tick(10);
        check("held frame not started", busy, 1'b0);
        check("frame4 read count", rd_log.size() - base, COLS*WPC);

        // frame 5: pending frame starts on enable; early tx_finish; reset in column 7
        enable = 1'b1;
        tick(1);
        check("pending start rd_en", rd_en, 1'b1);
        check("pending start rd_addr", rd_addr, 0);
        exp_perr = 1'b1;
        wait_new_column();
        column_body(0, 1'b0, 3);
        for (int c = 1; c < 7; c++) do_column(c, 1'b0);
        wait_new_column();
        check("col7 data", data_out, mem[7*WPC]);
        tick(2);
        pulse_next();
        check("col7 mid-fetch", rd_en, 1'b1);
        rst = 1'b1;
        tick(1);
        check("abort rd_en", rd_en, 1'b0);
        check("abort rd_addr", rd_addr, 0);
        check("abort data_out", data_out, 0);
        check("abort new_column", new_column, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort column_idx", column_idx, 0);
        check("abort protocol_err", protocol_err, 1'b0);
        rst = 1'b0;
        tick(3);
        check("post-abort idle", busy, 1'b0);
        check("post-abort no fetch", rd_en, 1'b0);
        pulse_ready();
        check("post-abort start", rd_en, 1'b1);
        check("post-abort addr", rd_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
